sdram_ch1_arbiter: RTL and testbench



---
 rtl/sdram_ch1_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_sdram_ch1_arbiter.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_ch1_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : sdram_ch1_arbiter
// Purpose : Round-robin sharing of SDRAM burst channel 1 among N masters,
//           with a ready watchdog that forces an error completion.
// Rev     : 1.0
// ============================================================================
module sdram_ch1_arbiter #(
    parameter int N       = 4,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [N-1:0]    req,
    input  logic [N-1:0]    rnw,
    input  logic [N*26-1:0] addr,
    input  logic [N*64-1:0] din,
    input  logic [N*8-1:0]  be,
    output logic [N-1:0]    ack,
    output logic [63:0]     dout,
    output logic            err,
    output logic            busy,
    output logic [25:0]     ch1_addr,
    output logic [63:0]     ch1_din,
    output logic [7:0]      ch1_be,
    output logic            ch1_rnw,
    output logic            ch1_req,
    input  logic [63:0]     ch1_dout,
    input  logic            ch1_ready
);
    localparam int IW = $clog2(N);

    typedef logic [IW-1:0] idx_t;
    typedef logic [IW:0]   sum_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam sum_t       c_n      = sum_t'(N);
    localparam idx_t       c_last   = idx_t'(N - 1);
    localparam logic [9:0] c_wd_max = 10'h3FF;
    localparam logic [9:0] c_wd_lim = 10'(TIMEOUT);

    state_t      state_q, state_d;
    idx_t        rr_q, rr_d;
    idx_t        g_q, g_d;
    logic [9:0]  wd_q, wd_d;
    logic [25:0] ch1_addr_q, ch1_addr_d;
    logic [63:0] ch1_din_q, ch1_din_d;
    logic [7:0]  ch1_be_q, ch1_be_d;
    logic        ch1_rnw_q, ch1_rnw_d;
    logic [N-1:0] ack_q, ack_d;
    logic        err_q, err_d;
    logic [63:0] dout_q, dout_d;

    logic [25:0] addr_a [N];
    logic [63:0] din_a  [N];
    logic [7:0]  be_a   [N];

    for (genvar i = 0; i < N; i++) begin : g_slice
        assign addr_a[i] = addr[26*i +: 26];
        assign din_a[i]  = din[64*i +: 64];
        assign be_a[i]   = be[8*i +: 8];
    end

    // First pending requester at or after rr_q, wrapping N-1 -> 0.
    sum_t w_sum;
    idx_t w_idx;
    idx_t w_grant;
    logic w_found;

    always_comb begin
        w_found = 1'b0;
        w_grant = rr_q;
        w_sum   = '0;
        w_idx   = '0;
        for (int k = 0; k < N; k++) begin
            w_sum = {1'b0, rr_q} + sum_t'(k);
            if (w_sum >= c_n) begin
                w_sum = w_sum - c_n;
            end
            w_idx = w_sum[IW-1:0];
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_grant = w_idx;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        g_d        = g_q;
        wd_d       = wd_q;
        ch1_addr_d = ch1_addr_q;
        ch1_din_d  = ch1_din_q;
        ch1_be_d   = ch1_be_q;
        ch1_rnw_d  = ch1_rnw_q;
        ack_d      = '0;
        err_d      = 1'b0;
        dout_d     = dout_q;
        case (state_q)
            S_IDLE: begin
                if (w_found) begin
                    g_d        = w_grant;
                    ch1_addr_d = addr_a[w_grant];
                    ch1_din_d  = din_a[w_grant];
                    ch1_be_d   = be_a[w_grant];
                    ch1_rnw_d  = rnw[w_grant];
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wd_d    = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A real ready wins over a watchdog expiring in the same cycle.
                if (ch1_ready) begin
                    if (ch1_rnw_q) begin
                        dout_d = ch1_dout;
                    end
                    ack_d[g_q] = 1'b1;
                    state_d    = S_DONE;
                end else if (wd_q == c_wd_lim) begin
                    ack_d[g_q] = 1'b1;
                    err_d      = 1'b1;
                    state_d    = S_DONE;
                end else if (wd_q != c_wd_max) begin
                    wd_d = wd_q + 10'd1;
                end
            end
            S_DONE: begin
                rr_d    = (g_q == c_last) ? '0 : g_q + idx_t'(1);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            rr_q       <= '0;
            g_q        <= '0;
            wd_q       <= '0;
            ch1_addr_q <= '0;
            ch1_din_q  <= '0;
            ch1_be_q   <= '0;
            ch1_rnw_q  <= 1'b0;
            ack_q      <= '0;
            err_q      <= 1'b0;
            dout_q     <= '0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            g_q        <= g_d;
            wd_q       <= wd_d;
            ch1_addr_q <= ch1_addr_d;
            ch1_din_q  <= ch1_din_d;
            ch1_be_q   <= ch1_be_d;
            ch1_rnw_q  <= ch1_rnw_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            dout_q     <= dout_d;
        end
    end

    assign ack      = ack_q;
    assign err      = err_q;
    assign dout     = dout_q;
    assign busy     = (state_q != S_IDLE);
    assign ch1_req  = (state_q == S_ISSUE);
    assign ch1_addr = ch1_addr_q;
    assign ch1_din  = ch1_din_q;
    assign ch1_be   = ch1_be_q;
    assign ch1_rnw  = ch1_rnw_q;

endmodule
`default_nettype wire

// File: tb/tb_sdram_ch1_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_sdram_ch1_arbiter
// Purpose : Directed self-checking bench for sdram_ch1_arbiter (N=4, TIMEOUT=16).
// Rev     : 1.0
// ============================================================================
module tb_sdram_ch1_arbiter;
    localparam int N   = 4;
    localparam int TMO = 16;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [N-1:0]    req;
    logic [N-1:0]    rnw;
    logic [N*26-1:0] addr;
    logic [N*64-1:0] din;
    logic [N*8-1:0]  be;
    logic [N-1:0]    ack;
    logic [63:0]     dout;
    logic            err;
    logic            busy;
    logic [25:0]     ch1_addr;
    logic [63:0]     ch1_din;
    logic [7:0]      ch1_be;
    logic            ch1_rnw;
    logic            ch1_req;
    logic [63:0]     ch1_dout;
    logic            ch1_ready;

    int n_checks = 0;
    int n_pass   = 0;
    logic [63:0] last_rd;

    always #5 clk = ~clk;

    sdram_ch1_arbiter #(.N(N), .TIMEOUT(TMO)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .rnw       (rnw),
        .addr      (addr),
        .din       (din),
        .be        (be),
        .ack       (ack),
        .dout      (dout),
        .err       (err),
        .busy      (busy),
        .ch1_addr  (ch1_addr),
        .ch1_din   (ch1_din),
        .ch1_be    (ch1_be),
        .ch1_rnw   (ch1_rnw),
        .ch1_req   (ch1_req),
        .ch1_dout  (ch1_dout),
        .ch1_ready (ch1_ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_slice(input int i, input logic r, input logic [25:0] a,
                             input logic [63:0] d, input logic [7:0] b);
        rnw[i]          = r;
        addr[26*i +: 26] = a;
        din[64*i +: 64]  = d;
        be[8*i +: 8]     = b;
    endtask

    // Waits (bounded) for the ch1_req pulse, answers with ready after lat cycles,
    // and returns the ack vector seen in the following cycle.
    task automatic run_txn(input int lat, input logic [63:0] data,
                           output logic [N-1:0] ack_seen, output logic [25:0] a_seen,
                           output bit ok);
        ok       = 1'b0;
        ack_seen = '0;
        a_seen   = '0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (ch1_req === 1'b1) ok = 1'b1;
            else tick();
        end
        if (ok) begin
            a_seen = ch1_addr;
            repeat (lat) tick();
            ch1_dout  = data;
            ch1_ready = 1'b1;
            tick();
            ch1_ready = 1'b0;
            ch1_dout  = '0;
            ack_seen  = ack;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b1; req = '0; rnw = '0; addr = '0; din = '0; be = '0;
        ch1_dout = '0; ch1_ready = 1'b0;
        #1 reset_n = 1'b0;
        #2;
        n_checks++;
        if ({ack, err, busy, ch1_req, ch1_rnw, ch1_be} !== '0)
            $display("FAIL reset_ctrl: got %b want 0", {ack, err, busy, ch1_req, ch1_rnw, ch1_be});
        else n_pass++;
        n_checks++;
        if (dout !== 64'h0 || ch1_din !== 64'h0 || ch1_addr !== 26'h0)
            $display("FAIL reset_data: dout=%h din=%h addr=%h want 0", dout, ch1_din, ch1_addr);
        else n_pass++;
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (2) tick();
        n_checks++;
        if (busy !== 1'b0 || ch1_req !== 1'b0)
            $display("FAIL reset_idle: busy=%b ch1_req=%b want 0 0", busy, ch1_req);
        else n_pass++;
    endtask

    task automatic test_single_read();
        int extra = 0;
        bit stable = 1'b1;
        set_slice(1, 1'b1, 26'h0000100, 64'h0, 8'hFF);
        req = 4'b0010;
        tick();
        n_checks++;
        if (ch1_req !== 1'b1 || ch1_addr !== 26'h0000100 || ch1_rnw !== 1'b1 || busy !== 1'b1)
            $display("FAIL read_issue: req=%b addr=%h rnw=%b busy=%b want 1 0000100 1 1",
                     ch1_req, ch1_addr, ch1_rnw, busy);
        else n_pass++;
        repeat (9) begin
            tick();
            if (ch1_req !== 1'b0) extra++;
            if (ch1_addr !== 26'h0000100 || ch1_rnw !== 1'b1) stable = 1'b0;
        end
        n_checks++;
        if (extra != 0 || !stable)
            $display("FAIL read_wait: extra_pulses=%0d stable=%0d want 0 1", extra, stable);
        else n_pass++;
        ch1_dout = 64'h1122334455667788; ch1_ready = 1'b1;
        tick();
        ch1_ready = 1'b0; ch1_dout = '0;
        n_checks++;
        if (ack !== 4'b0010 || err !== 1'b0 || busy !== 1'b1)
            $display("FAIL read_ack: ack=%b err=%b busy=%b want 0010 0 1", ack, err, busy);
        else n_pass++;
        n_checks++;
        if (dout !== 64'h1122334455667788)
            $display("FAIL read_dout: got %h want 1122334455667788", dout);
        else n_pass++;
        req = '0;
        tick();
        n_checks++;
        if (ack !== 4'b0000 || busy !== 1'b0)
            $display("FAIL read_after: ack=%b busy=%b want 0000 0", ack, busy);
        else n_pass++;
    endtask

    task automatic test_write();
        bit stable = 1'b1;
        set_slice(2, 1'b0, 26'h2A5A5A5, 64'hDEADBEEFCAFEF00D, 8'hF0);
        req = 4'b0100;
        tick();
        n_checks++;
        if (ch1_din !== 64'hDEADBEEFCAFEF00D || ch1_be !== 8'hF0 || ch1_rnw !== 1'b0 ||
            ch1_addr !== 26'h2A5A5A5)
            $display("FAIL write_issue: din=%h be=%h rnw=%b addr=%h want deadbeefcafef00d f0 0 2a5a5a5",
                     ch1_din, ch1_be, ch1_rnw, ch1_addr);
        else n_pass++;
        set_slice(0, 1'b1, 26'h1234567, 64'h0123456789ABCDEF, 8'h0F);
        repeat (4) begin
            tick();
            if (ch1_din !== 64'hDEADBEEFCAFEF00D || ch1_be !== 8'hF0 || ch1_rnw !== 1'b0 ||
                ch1_addr !== 26'h2A5A5A5) stable = 1'b0;
        end
        n_checks++;
        if (!stable) $display("FAIL write_hold: stable=%0d want 1", stable);
        else n_pass++;
        ch1_dout = 64'hBADBADBADBADBAD0; ch1_ready = 1'b1;
        tick();
        ch1_ready = 1'b0; ch1_dout = '0;
        n_checks++;
        if (ack !== 4'b0100 || err !== 1'b0)
            $display("FAIL write_ack: ack=%b err=%b want 0100 0", ack, err);
        else n_pass++;
        n_checks++;
        if (dout !== 64'h1122334455667788)
            $display("FAIL write_dout: got %h want 1122334455667788", dout);
        else n_pass++;
        req = '0;
        tick();
    endtask

    task automatic test_round_robin();
        logic [N-1:0] acks;
        logic [25:0]  a_s;
        bit ok;
        int g;
        reset_n = 1'b0; tick(); reset_n = 1'b1; tick();
        for (int i = 0; i < N; i++) set_slice(i, 1'b1, 26'h0001000 + 26'(i), 64'h0, 8'hFF);
        req = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            g = k % N;
            run_txn(2, 64'hA000 + 64'(k), acks, a_s, ok);
            n_checks++;
            if (!ok || acks !== 4'(1 << g) || a_s !== 26'h0001000 + 26'(g))
                $display("FAIL rr_grant%0d: ok=%0d ack=%b addr=%h want ack=%b addr=%h",
                         k, ok, acks, a_s, 4'(1 << g), 26'h0001000 + 26'(g));
            else n_pass++;
            req[g] = 1'b0;
            tick();
            if (k == 5) req = 4'b0011;
            else req[g] = 1'b1;
        end
        run_txn(3, 64'h5555000000000000, acks, a_s, ok);
        n_checks++;
        if (!ok || acks !== 4'b0001 || a_s !== 26'h0001000)
            $display("FAIL rr_wrap: ok=%0d ack=%b addr=%h want 0001 0001000", ok, acks, a_s);
        else n_pass++;
        last_rd = 64'h5555000000000000;
        req = '0;
        tick();
    endtask

    task automatic test_timeout();
        int early = 0;
        int stray = 0;
        set_slice(3, 1'b1, 26'h3000003, 64'h0, 8'hFF);
        req = 4'b1000;
        tick();
        n_checks++;
        if (ch1_req !== 1'b1 || ch1_addr !== 26'h3000003)
            $display("FAIL to_issue: req=%b addr=%h want 1 3000003", ch1_req, ch1_addr);
        else n_pass++;
        repeat (TMO + 1) begin
            tick();
            if (ack !== 4'b0000) early++;
        end
        tick();
        n_checks++;
        if (early != 0 || ack !== 4'b1000 || err !== 1'b1)
            $display("FAIL to_ack: early=%0d ack=%b err=%b want 0 1000 1", early, ack, err);
        else n_pass++;
        n_checks++;
        if (dout !== last_rd) $display("FAIL to_dout: got %h want %h", dout, last_rd);
        else n_pass++;
        req = '0;
        repeat (5) tick();
        ch1_dout = 64'hFFFFFFFFFFFFFFFF; ch1_ready = 1'b1;
        tick();
        ch1_ready = 1'b0; ch1_dout = '0;
        repeat (4) begin
            if (ack !== 4'b0000) stray++;
            tick();
        end
        n_checks++;
        if (stray != 0 || dout !== last_rd || busy !== 1'b0)
            $display("FAIL to_late_ready: stray=%0d dout=%h busy=%b want 0 %h 0",
                     stray, dout, busy, last_rd);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] acks;
        logic [25:0]  a_s;
        bit ok;
        int stray = 0;
        set_slice(2, 1'b1, 26'h0002222, 64'h0, 8'hFF);
        req = 4'b0100;
        run_txn(1, 64'h2222222222222222, acks, a_s, ok);
        n_checks++;
        if (!ok || acks !== 4'b0100) $display("FAIL rm_pre: ok=%0d ack=%b want 0100", ok, acks);
        else n_pass++;
        req = 4'b1000;
        tick();
        tick();
        n_checks++;
        if (ch1_req !== 1'b1 || ch1_addr !== 26'h3000003)
            $display("FAIL rm_issue: req=%b addr=%h want 1 3000003", ch1_req, ch1_addr);
        else n_pass++;
        repeat (3) tick();
        reset_n = 1'b0;
        req = '0;
        #1;
        n_checks++;
        if ({ack, err, busy, ch1_req, ch1_rnw, ch1_be} !== '0 || ch1_addr !== 26'h0 || dout !== 64'h0)
            $display("FAIL rm_async: ctrl=%b addr=%h dout=%h want 0",
                     {ack, err, busy, ch1_req, ch1_rnw, ch1_be}, ch1_addr, dout);
        else n_pass++;
        tick(); tick();
        reset_n = 1'b1;
        tick();
        ch1_dout = 64'h7777777777777777; ch1_ready = 1'b1;
        tick();
        ch1_ready = 1'b0; ch1_dout = '0;
        repeat (3) begin
            if (ack !== 4'b0000) stray++;
            tick();
        end
        n_checks++;
        if (stray != 0 || dout !== 64'h0 || busy !== 1'b0)
            $display("FAIL rm_stale: stray=%0d dout=%h busy=%b want 0 0 0", stray, dout, busy);
        else n_pass++;
        set_slice(0, 1'b1, 26'h0000AAA, 64'h0, 8'hFF);
        req = 4'b1001;
        run_txn(1, 64'hAAAA, acks, a_s, ok);
        n_checks++;
        if (!ok || acks !== 4'b0001 || a_s !== 26'h0000AAA)
            $display("FAIL rm_rr0: ok=%0d ack=%b addr=%h want 0001 0000aaa", ok, acks, a_s);
        else n_pass++;
        req = '0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] acks;
        logic [25:0]  a_s;
        bit ok;
        bit found = 1'b0;
        int cnt = 0;
        set_slice(0, 1'b1, 26'h0000B0B, 64'h0, 8'hFF);
        req = 4'b0001;
        run_txn(2, 64'h0B0B0B0B0B0B0B0B, acks, a_s, ok);
        n_checks++;
        if (!ok || acks !== 4'b0001 || busy !== 1'b1)
            $display("FAIL b2b_first: ok=%0d ack=%b busy=%b want 0001 1", ok, acks, busy);
        else n_pass++;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            cnt++;
            if (ch1_req === 1'b1) found = 1'b1;
        end
        n_checks++;
        if (!found || cnt + 1 != 3)
            $display("FAIL b2b_gap: found=%0d cycles_after_ready=%0d want 1 3", found, cnt + 1);
        else n_pass++;
        run_txn(1, 64'hC0C0C0C0C0C0C0C0, acks, a_s, ok);
        n_checks++;
        if (!ok || acks !== 4'b0001 || dout !== 64'hC0C0C0C0C0C0C0C0)
            $display("FAIL b2b_second: ok=%0d ack=%b dout=%h want 0001 c0c0c0c0c0c0c0c0",
                     ok, acks, dout);
        else n_pass++;
        req = '0;
        tick();
        tick();
        n_checks++;
        if (busy !== 1'b0 || ch1_req !== 1'b0)
            $display("FAIL b2b_idle: busy=%b ch1_req=%b want 0 0", busy, ch1_req);
        else n_pass++;
    endtask

    initial begin
        last_rd = '0;
        test_reset();
        test_single_read();
        test_write();
        test_round_robin();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
        $fatal(1);
    end

endmodule
`default_nettype wire
